seq_detect_param: RTL and testbench
===================================

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter SEQ_LEN, default 3, SHALL set the pattern length in bits; legal range 2..16.
REQ-002 Parameter CNT_W, default 8, SHALL set the match-counter width in bits; legal range 2..16.
REQ-003 Parameter RST_PAT, default 3'b101 (width SEQ_LEN), SHALL set the pattern value loaded at reset.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low (0 = reset).
REQ-006 inp  input  1  serial data bit.
REQ-007 in_valid  input  1  inp is sampled only in cycles where in_valid=1.
REQ-008 overlap  input  1  mode select: 1 = overlapping detection, 0 = non-overlapping detection.
REQ-009 pat_load  input  1  loads pat_in into the pattern register on this edge.
REQ-010 pat_in  input  SEQ_LEN  new pattern; bit SEQ_LEN-1 is the first bit expected on the line.
REQ-011 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-012 det  output  1  Mealy detect; combinational, asserted in the same cycle as the final matching bit.
REQ-013 det_q  output  1  registered copy of det; asserted one cycle after det.
REQ-014 match_cnt  output  CNT_W  count of detections, saturating.
REQ-015 cnt_sat  output  1  1 while match_cnt equals all-ones.

Function
REQ-016 The block SHALL hold the pattern register, a (SEQ_LEN-1)-bit history shift register of the most recent valid bits, and a fill counter in the range 0..SEQ_LEN-1.
REQ-017 det SHALL equal 1 iff in_valid=1, pat_load=0, fill=SEQ_LEN-1, and {history, inp} equals the pattern register.
REQ-018 det SHALL be 0 in every cycle where in_valid=0, independent of inp.
REQ-019 On a valid cycle with no detection, history SHALL shift left by one bit with inp entering at bit 0, and fill SHALL increment, saturating at SEQ_LEN-1.
REQ-020 On a detection with overlap=1, history and fill SHALL update exactly as in REQ-019.
REQ-021 On a detection with overlap=0, fill SHALL clear to 0 so that the matched bits are not reused; history contents are then don't-care.
REQ-022 overlap is sampled per cycle; a mode change SHALL take effect on the next valid bit, and the bits already in history SHALL be retained.
REQ-023 On pat_load=1, the pattern register SHALL take pat_in, fill SHALL clear to 0, and inp SHALL be discarded in that cycle even if in_valid=1.
REQ-024 match_cnt SHALL increment by 1 on each det=1 cycle and hold at 2^CNT_W-1 (no wrap).
REQ-025 cnt_clr=1 SHALL set match_cnt to 0 and take priority over a simultaneous increment; that detection is not counted, but det and det_q still assert.
REQ-026 det_q SHALL register det unconditionally every cycle.
REQ-027 With in_valid=0, all state except match_cnt and det_q SHALL hold; match_cnt and det_q SHALL follow REQ-024 to REQ-026.

Reset
REQ-028 While rst=0, the block SHALL asynchronously set pattern=RST_PAT, history=0, fill=0, match_cnt=0, and det_q=0.
REQ-029 While rst=0, det SHALL be 0 and cnt_sat SHALL be 0 (for CNT_W >= 1).
REQ-030 Reset asserted mid-stream SHALL discard any partial match; the first detection after release SHALL require SEQ_LEN fresh valid bits.

Verification
REQ-031 SEQ_LEN=3, pattern 101, overlap=1, in_valid=1, stream 1,0,1,0,1 -> det=1 on bits 3 and 5; det_q=1 one cycle later in each case; match_cnt=2.
REQ-032 Same stream with overlap=0 -> det=1 on bit 3 only; match_cnt=1; a further 0,1 (bits 6-7) -> det=1 on bit 7.
REQ-033 Stream 1,0 then in_valid=0 for 4 cycles with inp toggling, then 1 valid -> det=0 during the gap; det=1 on the resuming bit.
REQ-034 After bits 1,0, pat_load with pat_in=110, then stream 1,1,0 -> no detect on the next 1; det=1 on the final 0; pattern reads 110.
REQ-035 CNT_W=2, 5 detections -> match_cnt sequence 1,2,3,3,3 with cnt_sat=1 from the third detection; cnt_clr together with a detection -> match_cnt=0, det=1.
REQ-036 rst pulsed low asynchronously (mid-cycle) after bits 1,0 -> outputs cleared at once; after release, stream 1 -> det=0; then 1,0,1 -> det=1 on the final 1.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: programmable serial pattern detector with a Mealy
// detect, a registered detect copy and a saturating match counter.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   inp        serial data bit
//   in_valid   inp is sampled only when high
//   overlap    1 = overlapping detection, 0 = non-overlapping
//   pat_load   load pat_in into the pattern register
//   pat_in     new pattern; MSB is the first bit expected on the line
//   cnt_clr    synchronous clear of match_cnt
//   det        combinational detect on the final matching bit
//   det_q      det delayed by one cycle
//   match_cnt  saturating count of detections
//   cnt_sat    high while match_cnt is all ones
module seq_detect_param #(
    parameter int SEQ_LEN = 3,
    parameter int CNT_W = 8,
    parameter logic [SEQ_LEN-1:0] RST_PAT = 3'b101
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inp,
    input  logic               in_valid,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [SEQ_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               det,
    output logic               det_q,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    // fill counts valid bits held in history, 0..SEQ_LEN-1
    localparam int FW = $clog2(SEQ_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SEQ_LEN-1:0] pat;
    logic [SEQ_LEN-2:0] hist;
    logic [FW-1:0]      fill;
    logic [SEQ_LEN-1:0] win;
    logic               full;
    logic               hit;

    // candidate window: stored bits followed by the current bit
    assign win  = {hist, inp};
    assign full = (fill == FILL_MAX);
    assign hit  = full && (win == pat);

    // gated by rst so det is low throughout reset
    assign det = rst && in_valid && !pat_load && hit;

    assign cnt_sat = (match_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat  <= RST_PAT;
            hist <= '0;
            fill <= '0;
        end else if (pat_load) begin
            // a new pattern restarts matching; the bit on inp is dropped
            pat  <= pat_in;
            fill <= '0;
        end else if (in_valid) begin
            hist <= win[SEQ_LEN-2:0];
            if (det && !overlap) begin
                // non-overlapping: matched bits may not seed the next match
                fill <= '0;
            end else if (!full) begin
                fill <= fill + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= '0;
            det_q     <= 1'b0;
        end else begin
            det_q <= det;
            if (cnt_clr) begin
                match_cnt <= '0;
            end else if (det && !cnt_sat) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed and randomized checks of seq_detect_param
// against a queue-based behavioural model of the detector.
module tb_seq_detect_param;

    localparam int L = 3;

    logic         clk;
    logic         rst;
    logic         inp;
    logic         in_valid;
    logic         overlap;
    logic         pat_load;
    logic [L-1:0] pat_in;
    logic         cnt_clr;

    logic         det0, det_q0, sat0;
    logic [7:0]   cnt0;
    logic         det1, det_q1, sat1;
    logic [1:0]   cnt1;

    int n_checks = 0;
    int n_fail = 0;

    seq_detect_param #(.SEQ_LEN(L), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .det(det0), .det_q(det_q0),
        .match_cnt(cnt0), .cnt_sat(sat0)
    );

    seq_detect_param #(.SEQ_LEN(L), .CNT_W(2)) u1 (
        .clk(clk), .rst(rst), .inp(inp), .in_valid(in_valid),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .det(det1), .det_q(det_q1),
        .match_cnt(cnt1), .cnt_sat(sat1)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // q holds the valid bits usable for the next match, oldest first
    bit q[$];
    int mpat;
    int mcnt0;
    int mcnt1;
    int mdetq;

    function automatic int exp_det();
        int w;
        if (!rst || !in_valid || pat_load) return 0;
        if (q.size() < L - 1) return 0;
        w = 0;
        for (int j = L - 1; j >= 1; j--) w = (w << 1) | int'(q[q.size() - j]);
        w = (w << 1) | int'(inp);
        return (w == mpat) ? 1 : 0;
    endfunction

    always @(negedge clk or negedge rst) begin
        int ed;
        if (!rst) begin
            q.delete();
            mpat = 5;
            mcnt0 = 0;
            mcnt1 = 0;
            mdetq = 0;
        end
        if (!clk) begin
            ed = exp_det();
            chk("det0", int'(det0), ed);
            chk("det1", int'(det1), ed);
            chk("det_q0", int'(det_q0), mdetq);
            chk("det_q1", int'(det_q1), mdetq);
            chk("cnt0", int'(cnt0), mcnt0);
            chk("cnt1", int'(cnt1), mcnt1);
            chk("sat0", int'(sat0), (mcnt0 == 255) ? 1 : 0);
            chk("sat1", int'(sat1), (mcnt1 == 3) ? 1 : 0);
            if (rst) begin
                mdetq = ed;
                if (cnt_clr) begin
                    mcnt0 = 0;
                    mcnt1 = 0;
                end else if (ed == 1) begin
                    if (mcnt0 < 255) mcnt0++;
                    if (mcnt1 < 3) mcnt1++;
                end
                if (pat_load) begin
                    mpat = int'(pat_in);
                    q.delete();
                end else if (in_valid) begin
                    if (ed == 1 && !overlap) begin
                        q.delete();
                    end else begin
                        q.push_back(inp);
                        if (q.size() > 16) void'(q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv(input logic v, input logic b, input logic ov,
                       input logic pl, input logic [L-1:0] pi,
                       input logic cc);
        @(posedge clk);
        #1;
        in_valid = v;
        inp = b;
        overlap = ov;
        pat_load = pl;
        pat_in = pi;
        cnt_clr = cc;
        @(negedge clk);
        #1;
    endtask

    task automatic bitv(input logic b, input logic ov);
        drv(1'b1, b, ov, 1'b0, '0, 1'b0);
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        pat_load = 1'b0;
        cnt_clr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        inp = 1'b1;
        in_valid = 1'b1;
        overlap = 1'b1;
        pat_load = 1'b0;
        pat_in = '0;
        cnt_clr = 1'b0;

        // reset state with a live-looking input
        repeat (2) @(posedge clk);
        #7;
        chk("rst_det", int'(det0), 0);
        chk("rst_det_q", int'(det_q0), 0);
        chk("rst_cnt", int'(cnt0), 0);
        chk("rst_sat", int'(sat1), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;

        // overlapping 1,0,1,0,1
        bitv(1, 1); chk("ov_b1", int'(det0), 0);
        bitv(0, 1); chk("ov_b2", int'(det0), 0);
        bitv(1, 1); chk("ov_b3", int'(det0), 1);
        bitv(0, 1); chk("ov_b4_dq", int'(det_q0), 1);
        bitv(1, 1); chk("ov_b5", int'(det0), 1);
        idle();     chk("ov_dq5", int'(det_q0), 1);
        chk("ov_cnt", int'(cnt0), 2);

        // non-overlapping 1,0,1,0,1,0,1
        do_reset();
        bitv(1, 0);
        bitv(0, 0);
        bitv(1, 0); chk("no_b3", int'(det0), 1);
        bitv(0, 0);
        bitv(1, 0); chk("no_b5", int'(det0), 0);
        chk("no_cnt", int'(cnt0), 1);
        bitv(0, 0); chk("no_b6", int'(det0), 0);
        bitv(1, 0); chk("no_b7", int'(det0), 1);

        // invalid gap with toggling inp
        do_reset();
        bitv(1, 1);
        bitv(0, 1);
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, logic'(i[0]), 1'b1, 1'b0, '0, 1'b0);
            chk("gap_det", int'(det0), 0);
        end
        bitv(1, 1); chk("gap_resume", int'(det0), 1);

        // pattern load discards the bit and restarts
        do_reset();
        bitv(1, 1);
        bitv(0, 1);
        drv(1'b1, 1'b1, 1'b1, 1'b1, 3'b110, 1'b0);
        chk("ld_cycle", int'(det0), 0);
        bitv(1, 1); chk("ld_b1", int'(det0), 0);
        bitv(1, 1); chk("ld_b2", int'(det0), 0);
        bitv(0, 1); chk("ld_b3", int'(det0), 1);

        // saturation on the 2-bit counter, then clear with a detection
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            bitv(logic'(i % 2), 1);
            if (i >= 4 && i % 2 == 0) begin
                chk("sat_cnt1", int'(cnt1), ((i - 2) / 2 > 3) ? 3 : (i - 2) / 2);
                chk("sat_flag1", int'(sat1), (i >= 8) ? 1 : 0);
            end
        end
        chk("wide_cnt0", int'(cnt0), 5);
        drv(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1);
        chk("clr_det", int'(det1), 1);
        idle();
        chk("clr_cnt1", int'(cnt1), 0);
        chk("clr_cnt0", int'(cnt0), 0);
        chk("clr_dq", int'(det_q1), 1);

        // asynchronous reset pulse mid-cycle
        do_reset();
        bitv(1, 1);
        bitv(0, 1);
        bitv(1, 1);
        bitv(1, 1);
        bitv(0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        inp = 1'b1;
        #1;
        chk("pre_pulse_det", int'(det0), 1);
        chk("pre_pulse_cnt", int'(cnt0), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("pulse_det", int'(det0), 0);
        chk("pulse_cnt", int'(cnt0), 0);
        chk("pulse_dq", int'(det_q0), 0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("post_b1", int'(det0), 0);
        bitv(1, 1); chk("post_b2", int'(det0), 0);
        bitv(0, 1); chk("post_b3", int'(det0), 0);
        bitv(1, 1); chk("post_b4", int'(det0), 1);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(3) != 0);
            inp = logic'($urandom_range(1));
            if ($urandom_range(9) == 0) overlap = ~overlap;
            pat_load = ($urandom_range(39) == 0);
            pat_in = L'($urandom_range(7));
            cnt_clr = ($urandom_range(59) == 0);
            if ($urandom_range(299) == 0) begin
                #2;
                rst = 1'b0;
                #1;
                rst = 1'b1;
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
